// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and types for the ID/EX stage.
//   XLEN/NUM_REGS/REG_AW : datapath width, register count, register address width
//   OPC_*                : supported major opcodes
//   FUNCT7_*             : legal funct7 encodings
//   *_LSB                : instruction field positions
//   ex_bundle_t          : contents of the ID/EX pipeline register
package riscv_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int IMM_LSB = 20;
  localparam int F7_LSB  = 25;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              illegal;
  } ex_bundle_t;

endpackage

// File: rtl/reg_file_2r1w.sv
// Integer register file: two asynchronous read ports, one synchronous write port.
//   clk, rst            : clock, asynchronous active-high reset (clears all registers)
//   ra_i/rb_i           : read addresses, rdata_a_o/rdata_b_o : read data
//   we_i, waddr_i, wdata_i : write port
// x0 reads as zero and ignores writes. A read of the register being written
// this cycle returns the incoming write data.
module reg_file_2r1w
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_i,
  input  logic [REG_AW-1:0] rb_i,
  output logic [XLEN-1:0]   rdata_a_o,
  output logic [XLEN-1:0]   rdata_b_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [REG_AW-1:0] a,
                                              input logic [XLEN-1:0]   stored);
    if (a == '0)                     return '0;
    else if (wr_en && waddr_i == a)  return wdata_i;
    else                             return stored;
  endfunction

  assign rdata_a_o = rd_port(ra_i, regs_q[ra_i]);
  assign rdata_b_o = rd_port(rb_i, regs_q[rb_i]);

endmodule

// File: rtl/id_ex_decode_stage.sv
// Instruction decode plus ID/EX pipeline register.
//   clk, rst                 : clock, asynchronous active-high reset
//   id_valid, id_instr       : incoming instruction; id_ready = !stall
//   stall, flush             : hazard hold / redirect squash (flush has priority)
//   wb_we, wb_rd, wb_data    : write-back port into the register file
//   ex_*                     : registered operands and control for execute
module id_ex_decode_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  output logic              id_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [6:0]        ex_opcode,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_illegal
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   rs1_data, rs2_data;
  logic [XLEN-1:0]   op2;
  logic              illegal;
  ex_bundle_t        ex_d, ex_q;

  assign opcode = id_instr[OPC_LSB +: 7];
  assign rd     = id_instr[RD_LSB  +: REG_AW];
  assign funct3 = id_instr[F3_LSB  +: 3];
  assign rs1    = id_instr[RS1_LSB +: REG_AW];
  assign rs2    = id_instr[RS2_LSB +: REG_AW];
  assign funct7 = id_instr[F7_LSB  +: 7];

  reg_file_2r1w u_rf (
    .clk       (clk),
    .rst       (rst),
    .ra_i      (rs1),
    .rb_i      (rs2),
    .rdata_a_o (rs1_data),
    .rdata_b_o (rs2_data),
    .we_i      (wb_we),
    .waddr_i   (wb_rd),
    .wdata_i   (wb_data)
  );

  always_comb begin
    illegal = 1'b1;
    op2     = '0;
    case (opcode)
      OPC_OP_IMM: begin
        illegal = 1'b0;
        op2     = {{(XLEN-12){id_instr[31]}}, id_instr[IMM_LSB +: 12]};
        // Shifts use the rs2 field as a zero-extended shamt; funct7 selects SRL/SRA.
        if (funct3 == F3_SLL) begin
          op2     = {{(XLEN-REG_AW){1'b0}}, rs2};
          illegal = (funct7 != FUNCT7_BASE);
        end else if (funct3 == F3_SRL_SRA) begin
          op2     = {{(XLEN-REG_AW){1'b0}}, rs2};
          illegal = !((funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT));
        end
      end
      OPC_OP: begin
        op2     = rs2_data;
        illegal = !((funct7 == FUNCT7_BASE) ||
                    ((funct7 == FUNCT7_ALT) &&
                     ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA))));
      end
      default: ;
    endcase
  end

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d.valid     = id_valid;
      ex_d.op1       = rs1_data;
      ex_d.op2       = op2;
      ex_d.opcode    = opcode;
      ex_d.funct3    = funct3;
      ex_d.funct7    = funct7;
      ex_d.rd        = rd;
      ex_d.reg_write = id_valid && !illegal && (rd != '0);
      ex_d.illegal   = id_valid && illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign id_ready     = !stall;
  assign ex_valid     = ex_q.valid;
  assign ex_op1       = ex_q.op1;
  assign ex_op2       = ex_q.op2;
  assign ex_opcode    = ex_q.opcode;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7    = ex_q.funct7;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
module tb_id_ex_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        id_ready;
  logic        stall, flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_op1, ex_op2;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_illegal;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  id_ex_decode_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_ready(id_ready), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        valid;
    logic [31:0] instr;
    logic        chk_data;
    logic        e_valid;
    logic [31:0] e_op1, e_op2;
    logic [6:0]  e_opc;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
    logic [4:0]  e_rd;
    logic        e_rw, e_ill;
  } vec_t;

  function automatic vec_t mk(logic we, logic [4:0] wrd, logic [31:0] wd,
                              logic v, logic [31:0] ins, logic cd,
                              logic ev, logic [31:0] o1, logic [31:0] o2,
                              logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                              logic [4:0] erd, logic rw, logic ill);
    vec_t r;
    r.wb_we = we; r.wb_rd = wrd; r.wb_data = wd; r.valid = v; r.instr = ins;
    r.chk_data = cd; r.e_valid = ev; r.e_op1 = o1; r.e_op2 = o2; r.e_opc = opc;
    r.e_f3 = f3; r.e_f7 = f7; r.e_rd = erd; r.e_rw = rw; r.e_ill = ill;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    else n_pass++;
  endtask

  task automatic chk_ex(input string tag, input vec_t e);
    chk({tag, " ex_valid"},     {31'b0, ex_valid},     {31'b0, e.e_valid});
    chk({tag, " ex_reg_write"}, {31'b0, ex_reg_write}, {31'b0, e.e_rw});
    chk({tag, " ex_illegal"},   {31'b0, ex_illegal},   {31'b0, e.e_ill});
    if (e.chk_data) begin
      chk({tag, " ex_op1"},    ex_op1, e.e_op1);
      chk({tag, " ex_op2"},    ex_op2, e.e_op2);
      chk({tag, " ex_opcode"}, {25'b0, ex_opcode}, {25'b0, e.e_opc});
      chk({tag, " ex_funct3"}, {29'b0, ex_funct3}, {29'b0, e.e_f3});
      chk({tag, " ex_funct7"}, {25'b0, ex_funct7}, {25'b0, e.e_f7});
      chk({tag, " ex_rd"},     {27'b0, ex_rd},     {27'b0, e.e_rd});
    end
  endtask

  task automatic drive(input vec_t v, input logic st, input logic fl);
    wb_we = v.wb_we; wb_rd = v.wb_rd; wb_data = v.wb_data;
    id_valid = v.valid; id_instr = v.instr; stall = st; flush = fl;
  endtask

  vec_t vecs[$];
  vec_t zero_e, held, e;

  initial begin
    zero_e = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //         we rd wdata         v instr         cd  ev op1           op2           opc   f3 f7    rd rw ill
    vecs.push_back(mk(1, 5, 32'h10,       0, 32'h0,        1, 0, 0,           0,            7'h00, 0, 7'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'hFFD28313, 1, 1, 32'h10,      32'hFFFFFFFD, 7'h13, 0, 7'h7F, 6, 1, 0));
    vecs.push_back(mk(1, 1, 7,            1, 32'h402081B3, 1, 1, 7,           0,            7'h33, 0, 7'h20, 3, 1, 0));
    vecs.push_back(mk(1, 2, 9,            1, 32'h402081B3, 1, 1, 7,           9,            7'h33, 0, 7'h20, 3, 1, 0));
    vecs.push_back(mk(1, 0, 32'hDEADBEEF, 1, 32'h00000233, 1, 1, 0,           0,            7'h33, 0, 7'h00, 4, 1, 0));
    vecs.push_back(mk(1, 8, 32'h80000000, 1, 32'h00100013, 1, 1, 0,           1,            7'h13, 0, 7'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h40345393, 1, 1, 32'h80000000, 3,           7'h13, 5, 7'h20, 7, 1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h02345393, 1, 1, 32'h80000000, 3,           7'h13, 5, 7'h01, 7, 0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 32'h40209233, 1, 1, 7,           9,            7'h33, 1, 7'h20, 4, 0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 32'h123452B7, 1, 1, 32'h80000000, 0,           7'h37, 5, 7'h09, 5, 0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 32'h01F09493, 1, 1, 7,           31,           7'h13, 1, 7'h00, 9, 1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h80000513, 1, 1, 0,           32'hFFFFF800, 7'h13, 0, 7'h40, 10, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 32'hFFD28313, 0, 0, 0,           0,            0,     0, 0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h4020D233, 1, 1, 7,           9,            7'h33, 5, 7'h20, 4, 1, 0));

    rst = 1'b1;
    drive(zero_e, 0, 0);
    #12;
    chk_ex("reset", zero_e);
    chk("reset id_ready", {31'b0, id_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i], 0, 0);
      @(negedge clk);
      chk_ex($sformatf("vec%0d", i), vecs[i]);
    end

    // Stall: capture ADDI, then hold it for 3 cycles while ID input and x5 change.
    held = mk(0, 0, 0, 1, 32'hFFD28313, 1, 1, 32'h10, 32'hFFFFFFFD, 7'h13, 0, 7'h7F, 6, 1, 0);
    drive(held, 0, 0);
    @(negedge clk);
    chk_ex("stall_load", held);
    for (int c = 0; c < 3; c++) begin
      drive(mk(1, 5, 32'h55 + c, 1, 32'h402081B3 + (c << 7), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0);
      #1;
      chk($sformatf("stall%0d id_ready", c), {31'b0, id_ready}, 32'd0);
      @(negedge clk);
      chk_ex($sformatf("stall%0d hold", c), held);
    end

    // x5 was last written 0x57 during the stall; ADD x4,x5,x0 sees it.
    e = mk(0, 0, 0, 1, 32'h00028233, 1, 1, 32'h57, 0, 7'h33, 0, 7'h00, 4, 1, 0);
    drive(e, 0, 0);
    #1;
    chk("unstall id_ready", {31'b0, id_ready}, 32'd1);
    @(negedge clk);
    chk_ex("after_stall", e);

    // Flush wins over stall.
    drive(e, 1, 1);
    @(negedge clk);
    chk_ex("flush_stall", zero_e);

    // Async reset between edges.
    drive(e, 0, 0);
    @(negedge clk);
    chk_ex("pre_reset", e);
    #2 rst = 1'b1;
    #1;
    chk_ex("async_reset", zero_e);
    @(negedge clk);
    rst = 1'b0;
    e.e_op1 = 0;
    drive(e, 0, 0);
    @(negedge clk);
    chk_ex("post_reset_x5", e);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_decode_stage.md
Name: id_ex_decode_stage

Overview:
- Instruction-decode stage plus ID/EX pipeline register of the baseline 5-stage RISC-V pipeline.
- Takes a 32-bit fetched instruction and reads rs1/rs2 from an internal 32x32 register file, which includes the WB write port.
- Builds the ALU operands and registers op1, op2, opcode, funct3, funct7, rd and control for the execute stage.
- Handles stall, flush, the x0 rule and WB-to-ID write-through.

Parameters:
- XLEN, 32, datapath width.
- NUM_REGS, 32, number of architectural registers.
- REG_AW, 5, register address width (log2 NUM_REGS).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- id_valid  input  1  id_instr holds a valid instruction this cycle
- id_instr  input  32  fetched instruction
- id_ready  output  1  stage accepts an instruction this cycle (= !stall)
- stall  input  1  hazard unit hold request
- flush  input  1  squash request (branch/jump redirect)
- wb_we  input  1  register-file write enable
- wb_rd  input  REG_AW  write address
- wb_data  input  XLEN  write data
- ex_valid  output  1  EX-stage entry is valid
- ex_op1  output  XLEN  ALU operand 1
- ex_op2  output  XLEN  ALU operand 2
- ex_opcode  output  7  instr[6:0]
- ex_funct3  output  3  instr[14:12]
- ex_funct7  output  7  instr[31:25]
- ex_rd  output  REG_AW  destination register
- ex_reg_write  output  1  write-back required
- ex_illegal  output  1  unsupported opcode or funct pair

Behaviour:
- Reset (async, rst=1):
  - All ex_* outputs are 0 immediately; ex_valid=0.
  - Register file is cleared to 0.
  - Reset mid-stall or mid-write discards all state.
- Register file:
  - Written on clk rising edge when wb_we=1 and wb_rd!=0.
  - x0 always reads 0; writes to x0 are ignored.
- Write-through: a combinational read of the register that WB writes in the same cycle returns wb_data, not the stale value (rd!=0 only).
- Decode, combinational from id_instr:
  - rs1=[19:15], rs2=[24:20], rd=[11:7].
  - op1 = R[rs1].
- opcode 0010011 (I-type ALU):
  - op2 = sign-extended instr[31:20].
  - For funct3 001/101, op2 = zero-extended instr[24:20] (shamt) and funct7 = instr[31:25].
  - Legal funct7 for 001: 0000000. Legal funct7 for 101: 0000000 or 0100000. Anything else is illegal.
- opcode 0110011 (R-type):
  - op2 = R[rs2].
  - Legal {funct7,funct3}: 0000000 with any funct3, plus 0100000 with funct3 000 or 101. Anything else is illegal.
- Any other opcode: illegal=1, op2=0.
- reg_write = valid && !illegal && rd!=0.
- Pipeline register update, priority order:
  1. rst: clear everything.
  2. flush=1: ex_valid<=0, ex_reg_write<=0, ex_illegal<=0; data fields don't-care but driven to 0. Flush wins over a simultaneous stall.
  3. stall=1: all ex_* hold their values; the instruction in ID is not consumed (upstream holds it).
  4. Otherwise: load decoded fields. ex_valid<=id_valid; ex_reg_write and ex_illegal are gated by id_valid.
- Latency: instruction presented at edge N appears on ex_* after edge N+1 (1 cycle).
- id_ready = !stall, combinational.
- A WB write during a stall does not refresh already-captured ex_op1/ex_op2. Hazard/forwarding logic owns that case.
- id_valid=0 with no stall/flush loads a bubble: ex_valid=0, ex_reg_write=0.

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants OPC_OP_IMM=7'b0010011 and OPC_OP=7'b0110011.
  - FUNCT7_BASE=7'b0000000 and FUNCT7_ALT=7'b0100000.
  - Field-position localparams.
  - XLEN and REG_AW.
- One sub-module, reg_file_2r1w: two async read ports, one sync write port, x0 hardwired, write-through bypass, async reset.
- Decode and pipeline register stay in id_ex_decode_stage.

Test Plan:
- Write: wb_we=1, wb_rd=5, wb_data=0x0000_0010. Then issue ADDI x6,x5,-3 (0xFFD28313). Expect next cycle: ex_op1=0x10, ex_op2=0xFFFF_FFFD, ex_opcode=0x13, ex_funct3=0, ex_rd=6, ex_reg_write=1, ex_valid=1.
- Write-through: x1=7 and x2=9 are being written by WB in the same cycle as SUB x3,x1,x2 (0x402081B3) is decoded. Expect ex_op1=7, ex_op2=9, ex_funct7=0x20, ex_funct3=0.
- x0: wb_we=1, wb_rd=0, wb_data=0xDEAD_BEEF. Then ADD x4,x0,x0. Expect ex_op1=0, ex_op2=0. Also ADDI x0,x0,1: expect ex_reg_write=0, ex_valid=1.
- SRAI x7,x8,3 (0x40345393): expect ex_op2=3, ex_funct7=0x20, ex_illegal=0. Instr with funct7=0x01, funct3=101, opcode 0010011: expect ex_illegal=1, ex_reg_write=0.
- Stall/flush:
  - Load ADDI, then assert stall for 3 cycles while changing id_instr. Expect ex_* constant and id_ready=0.
  - Assert stall=1 and flush=1 together. Expect ex_valid=0 and ex_reg_write=0 next cycle.
- Async reset: assert rst mid-stream between clock edges. Expect all ex_* =0 before the next edge. After deassert, reading x5 returns 0.
